// File: rtl/keypad_scan_4x4_pkg.sv
// Shared encodings and helpers for the 4x4 keypad scanner.
package keypad_scan_4x4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_SCAN     = 3'd2,
    ST_PRESSED  = 3'd3,
    ST_REL_DB   = 3'd4
  } scan_state_e;

  localparam logic [3:0] ROW_ALL_LOW = 4'b0000;
  localparam logic [3:0] ROW_RELEASE = 4'b1111;
  localparam logic [3:0] COL_NONE    = 4'b1111;

  // Index of the lowest active-low column; callers only use it when some bit is low.
  function automatic logic [1:0] low_col_idx(input logic [3:0] col);
    logic [1:0] idx;
    if (col[0] == 1'b0) begin
      idx = 2'd0;
    end else if (col[1] == 1'b0) begin
      idx = 2'd1;
    end else if (col[2] == 1'b0) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Row drive pattern with only row idx pulled low.
  function automatic logic [3:0] row_one_low(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scan_4x4_if.sv
// Keypad pins plus the decoded key report toward the time-set / mode logic.
interface keypad_scan_4x4_if;
  logic       en;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport slave (
    input  en,
    input  col,
    output row,
    output key_code,
    output key_valid,
    output key_held
  );

  modport master (
    output en,
    output col,
    input  row,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_4x4_tick.sv
// Scan tick generator: one-clock tick every SCAN_DIV clocks while enabled.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DIV_PRE  = CW'(SCAN_DIV - 2);
  localparam logic [CW-1:0] DIV_ONE  = CW'(1);

  logic [CW-1:0] div_r;
  logic          tick_r;

  // Divider: counts 0..SCAN_DIV-1 while enabled, held at zero when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
    end else if (!en) begin
      div_r <= '0;
    end else if (div_r == DIV_LAST) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Tick is registered one count early so it is high exactly while the divider sits at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r <= 1'b0;
    end else begin
      tick_r <= en && (div_r == DIV_PRE);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 active-low keypad scanner: debounced press detection, row scan, one pulse per accepted key.
module keypad_scan_4x4 #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DB_TICKS = 20
) (
  input logic               clk,
  input logic               rst_n,
  keypad_scan_4x4_if.slave  kp
);
  import keypad_scan_4x4_pkg::*;

  // Debounce counter is at least 5 bits; DB_TICKS must be >= 2.
  localparam int unsigned DBW = ($clog2(DB_TICKS + 1) > 5) ? $clog2(DB_TICKS + 1) : 5;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);
  localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

  logic              tick_s;
  logic [3:0]        col_meta_r;
  logic [3:0]        col_s;
  logic              hit_s;
  scan_state_e       state_r, state_nxt;
  logic [DBW-1:0]    db_cnt_r, db_nxt, db_inc_s;
  logic [1:0]        ridx_r, ridx_nxt;
  logic              accept_s, release_s;
  logic [3:0]        row_r, row_nxt;
  logic [3:0]        key_code_r, code_nxt;
  logic              key_valid_r, valid_nxt;
  logic              key_held_r, held_nxt;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (kp.en),
    .tick  (tick_s)
  );

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_r <= COL_NONE;
      col_s      <= COL_NONE;
    end else begin
      col_meta_r <= kp.col;
      col_s      <= col_meta_r;
    end
  end

  assign hit_s    = (col_s != COL_NONE);
  assign db_inc_s = db_cnt_r + DB_ONE;

  // FSM state, debounce count and scanned row index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      db_cnt_r <= '0;
      ridx_r   <= 2'd0;
    end else begin
      state_r  <= state_nxt;
      db_cnt_r <= db_nxt;
      ridx_r   <= ridx_nxt;
    end
  end

  // Next-state logic; every decision waits for a scan tick, disable wins over everything.
  always_comb begin
    state_nxt = state_r;
    db_nxt    = db_cnt_r;
    ridx_nxt  = ridx_r;
    accept_s  = 1'b0;
    release_s = 1'b0;
    if (!kp.en) begin
      state_nxt = ST_IDLE;
      db_nxt    = '0;
      ridx_nxt  = 2'd0;
    end else if (tick_s) begin
      case (state_r)
        ST_IDLE: begin
          if (hit_s) begin
            state_nxt = ST_PRESS_DB;
            db_nxt    = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_PRESS_DB: begin
          if (!hit_s) begin
            state_nxt = ST_IDLE;
          end else if (db_inc_s == DB_LAST) begin
            state_nxt = ST_SCAN;
            ridx_nxt  = 2'd0;
          end else begin
            db_nxt = db_inc_s;
          end
        end
        ST_SCAN: begin
          if (hit_s) begin
            state_nxt = ST_PRESSED;
            accept_s  = 1'b1;
          end else if (ridx_r == 2'd3) begin
            state_nxt = ST_IDLE;
          end else begin
            ridx_nxt = ridx_r + 2'd1;
          end
        end
        ST_PRESSED: begin
          if (!hit_s) begin
            state_nxt = ST_REL_DB;
            db_nxt    = '0;
          end else begin
            state_nxt = ST_PRESSED;
          end
        end
        ST_REL_DB: begin
          if (hit_s) begin
            state_nxt = ST_PRESSED;
          end else if (db_inc_s == DB_LAST) begin
            state_nxt = ST_IDLE;
            release_s = 1'b1;
          end else begin
            db_nxt = db_inc_s;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          db_nxt    = '0;
          ridx_nxt  = 2'd0;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // Output decode from the upcoming state so row drive and key report are registered.
  always_comb begin
    row_nxt   = ROW_ALL_LOW;
    code_nxt  = key_code_r;
    valid_nxt = 1'b0;
    held_nxt  = key_held_r;
    if (!kp.en) begin
      row_nxt  = ROW_RELEASE;
      held_nxt = 1'b0;
    end else begin
      if (state_nxt == ST_SCAN) begin
        row_nxt = row_one_low(ridx_nxt);
      end else begin
        row_nxt = ROW_ALL_LOW;
      end
      if (accept_s) begin
        code_nxt  = {ridx_r, low_col_idx(col_s)};
        valid_nxt = 1'b1;
        held_nxt  = 1'b1;
      end else if (release_s) begin
        held_nxt = 1'b0;
      end else begin
        held_nxt = key_held_r;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r       <= ROW_RELEASE;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      row_r       <= row_nxt;
      key_code_r  <= code_nxt;
      key_valid_r <= valid_nxt;
      key_held_r  <= held_nxt;
    end
  end

  assign kp.row       = row_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with a behavioural keypad matrix model.
module tb_keypad_scan_4x4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keys;
  logic [3:0]  col_drv;
  int          n_checks = 0;
  int          n_errors = 0;
  int          valid_cnt = 0;
  int          held_rise_cnt = 0;
  int          consec_cnt = 0;
  logic        prev_valid = 1'b0;
  logic        prev_held = 1'b0;
  int          base_v;
  int          base_h;
  bit          seen;

  keypad_scan_4x4_if kif();

  keypad_scan_4x4 #(.SCAN_DIV(4), .DB_TICKS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  // Keypad model: column c pulled low when a pressed key sits on a driven-low row.
  always_comb begin
    col_drv = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && (kif.row[r] == 1'b0)) col_drv[c] = 1'b0;
      end
    end
  end
  assign kif.col = col_drv;

  // Pulse / held monitors sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (kif.key_valid) valid_cnt <= valid_cnt + 1;
      if (kif.key_valid && prev_valid) consec_cnt <= consec_cnt + 1;
      if (kif.key_held && !prev_held) held_rise_cnt <= held_rise_cnt + 1;
    end
    prev_valid <= kif.key_valid;
    prev_held  <= kif.key_held;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (kif.key_valid) ok = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    keys   = 16'h0000;
    kif.en = 1'b1;
    rst_n  = 1'b0;

    // 1: reset state
    repeat (3) @(negedge clk);
    check_val("rst_row", kif.row, 4'hF);
    check_val("rst_code", kif.key_code, 4'h0);
    check_val("rst_valid", kif.key_valid, 1'b0);
    check_val("rst_held", kif.key_held, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_row", kif.row, 4'h0);

    // 2: single key (2,1)
    keys[2*4+1] = 1'b1;
    wait_valid(80, seen);
    check_val("t2_seen", seen, 1'b1);
    check_val("t2_code", kif.key_code, 4'h9);
    check_val("t2_held", kif.key_held, 1'b1);
    repeat (30) @(negedge clk);
    check_val("t2_one_pulse", valid_cnt, 1);
    keys = 16'h0000;
    repeat (6) @(negedge clk);
    check_val("t2_held_early", kif.key_held, 1'b1);
    repeat (14) @(negedge clk);
    check_val("t2_released", kif.key_held, 1'b0);
    check_val("t2_no_rel_pulse", valid_cnt, 1);

    // 3: bouncing key (0,0) never accepted
    base_v = valid_cnt;
    base_h = held_rise_cnt;
    for (int k = 0; k < 3; k++) begin
      keys[0] = 1'b1;
      repeat (4) @(negedge clk);
      keys[0] = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check_val("t3_no_pulse", valid_cnt - base_v, 0);
    check_val("t3_no_held", held_rise_cnt - base_h, 0);
    check_val("t3_held_low", kif.key_held, 1'b0);

    // 4: keys (1,3) and (3,0) together, lower row wins
    base_v = valid_cnt;
    keys[1*4+3] = 1'b1;
    keys[3*4+0] = 1'b1;
    wait_valid(80, seen);
    check_val("t4_seen", seen, 1'b1);
    check_val("t4_code", kif.key_code, 4'h7);
    repeat (30) @(negedge clk);
    check_val("t4_one_pulse", valid_cnt - base_v, 1);
    keys = 16'h0000;
    repeat (24) @(negedge clk);

    // 5: disable while pressed, re-enable with key still down
    keys[15] = 1'b1;
    wait_valid(80, seen);
    check_val("t5_seen", seen, 1'b1);
    check_val("t5_code", kif.key_code, 4'hF);
    repeat (8) @(negedge clk);
    kif.en = 1'b0;
    @(negedge clk);
    check_val("t5_dis_row", kif.row, 4'hF);
    check_val("t5_dis_held", kif.key_held, 1'b0);
    check_val("t5_dis_code", kif.key_code, 4'hF);
    repeat (5) @(negedge clk);
    check_val("t5_dis_valid", kif.key_valid, 1'b0);
    base_v = valid_cnt;
    kif.en = 1'b1;
    @(negedge clk);
    check_val("t5_en_row", kif.row, 4'h0);
    wait_valid(80, seen);
    check_val("t5_reseen", seen, 1'b1);
    check_val("t5_recode", kif.key_code, 4'hF);
    check_val("t5_reheld", kif.key_held, 1'b1);
    repeat (3) @(negedge clk);
    check_val("t5_new_pulse", valid_cnt - base_v, 1);
    keys = 16'h0000;
    repeat (24) @(negedge clk);

    // 6: re-closure during release debounce (timing referenced to the valid tick edge)
    keys[1*4+2] = 1'b1;
    wait_valid(80, seen);
    check_val("t6_seen", seen, 1'b1);
    check_val("t6_code", kif.key_code, 4'h6);
    repeat (4) @(negedge clk);
    base_v = valid_cnt;
    keys[1*4+2] = 1'b0;
    repeat (4) @(negedge clk);
    keys[1*4+2] = 1'b1;
    repeat (4) @(negedge clk);
    check_val("t6_held_glitch", kif.key_held, 1'b1);
    keys[1*4+2] = 1'b0;
    repeat (11) @(negedge clk);
    check_val("t6_held_before", kif.key_held, 1'b1);
    @(negedge clk);
    check_val("t6_held_after", kif.key_held, 1'b0);
    repeat (20) @(negedge clk);
    check_val("t6_no_pulse", valid_cnt - base_v, 0);

    check_val("no_consec_valid", consec_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
